// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Purpose:
//   Shared definitions for the counter project. This package holds the
//   direction encoding of the up/down counters and a parameter legality
//   macro. Every counter block uses the macro to reject a WIDTH/MODULUS/
//   RESET_VAL combination that cannot be built.
//
// Contents:
//   COUNTER_PARAMS_LEGAL(w, m, r) : macro, true when 2 <= w <= 16,
//                                   2 <= m <= 2**w and r < m
//   DIR_UP / DIR_DOWN             : encoding of the 'up' input
// ----------------------------------------------------------------------------

`ifndef COUNTER_PKG_MACROS
`define COUNTER_PKG_MACROS

// The macro lives outside the package because macros are text
// substitutions and cannot be imported. It is written as one expression so
// that it can feed a localparam directly.
`define COUNTER_PARAMS_LEGAL(w, m, r) \
    (((w) >= 2) && ((w) <= 16) && ((m) >= 2) && ((m) <= (1 << (w))) && \
     ((r) >= 0) && ((r) < (m)))

`endif

package counter_pkg;

    // Encoding of the 'up' port. A cascaded stage and its driver share these
    // constants, so the two always agree on which level counts up.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_step_unit.sv
// ----------------------------------------------------------------------------
// mod_step_unit
//
// Purpose:
//   Combinational modulo-MODULUS step. Given the present count, it computes
//   the next count after one increment or decrement by (step + cin). It also
//   reports whether that move crossed the modulus boundary.
//
// Parameters:
//   WIDTH    : bit width of count and step
//   MODULUS  : count range 0 .. MODULUS-1
//
// Ports:
//   count      in  WIDTH  present count (always < MODULUS)
//   step       in  WIDTH  increment magnitude
//   cin        in  1      extra +1 added to step (cascade carry-in)
//   up         in  1      DIR_UP = add, DIR_DOWN = subtract
//   next_count out WIDTH  count after the move
//   wrap_next  out 1      boundary crossed or a full revolution skipped
// ----------------------------------------------------------------------------

module mod_step_unit
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             cin,
    input  logic             up,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_next
);

    // The arithmetic is done in WIDTH+1 bits. MODULUS can be as large as
    // 2**WIDTH, and step+cin can reach 2**WIDTH, so neither value fits in
    // WIDTH bits.
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH:0] step_cin;
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] count_w;
    logic [WIDTH:0] sum_w;
    logic           skip;

    // Form the effective increment. step+cin is reduced modulo MODULUS.
    // Because the divisor is a constant, the reduction collapses into fixed
    // logic at elaboration time.
    // If step+cin is already MODULUS or more, the counter jumps over at least
    // one whole revolution. That case must raise wrap even when the reduced
    // increment is zero.
    always_comb begin
        step_cin = {1'b0, step} + {{WIDTH{1'b0}}, cin};
        inc_w    = step_cin % MOD_W;
        skip     = (step_cin >= MOD_W);
        count_w  = {1'b0, count};
        sum_w    = count_w + inc_w;
    end

    // Apply the increment in the chosen direction and fold the result back
    // into 0 .. MODULUS-1.
    // Counting up, one conditional subtract is enough: count and inc are both
    // below MODULUS, so their sum is below 2*MODULUS.
    // Counting down, an underflow is repaired by adding MODULUS back. Adding
    // before subtracting keeps the intermediate value non-negative.
    // With MODULUS = 2**WIDTH the same comparisons become plain WIDTH-bit
    // wrap-around, because MOD_W is exactly the carry weight.
    always_comb begin
        next_count = count;
        wrap_next  = 1'b0;
        case (up)
            DIR_UP: begin
                if (sum_w >= MOD_W) begin
                    next_count = WIDTH'(sum_w - MOD_W);
                    wrap_next  = 1'b1;
                end else begin
                    next_count = WIDTH'(sum_w);
                end
            end
            DIR_DOWN: begin
                if (count_w >= inc_w) begin
                    next_count = WIDTH'(count_w - inc_w);
                end else begin
                    next_count = WIDTH'(count_w + MOD_W - inc_w);
                    wrap_next  = 1'b1;
                end
            end
        endcase
        if (skip) begin
            wrap_next = 1'b1;
        end
    end

endmodule : mod_step_unit

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
//
// Purpose:
//   Loadable modulo-MODULUS up/down counter and accumulator. On each enabled
//   cycle the count moves by (step + cin) in the chosen direction and wraps
//   modulo MODULUS. Outputs are a registered one-cycle wrap pulse and a
//   sticky overflow flag.
//   Stages cascade by driving an upper stage's cin from a lower stage's wrap.
//   The upper stage then lags the lower one by a single cycle.
//
// Parameters:
//   WIDTH     : count/step/load width (2..16)
//   MODULUS   : count range 0 .. MODULUS-1 (2 .. 2**WIDTH)
//   RESET_VAL : count after reset (< MODULUS)
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset, overrides everything
//   en         in  1      count enable
//   load       in  1      synchronous load of load_val (beats en)
//   load_val   in  WIDTH  value to load; out of range saturates to MODULUS-1
//   up         in  1      1 = count up, 0 = count down
//   step       in  WIDTH  increment magnitude
//   cin        in  1      extra +1 to the increment
//   clear_ovf  in  1      clears ovf_sticky unless a set event occurs
//   count      out WIDTH  current count, registered
//   wrap       out 1      one-cycle registered boundary pulse
//   ovf_sticky out 1      set on wrap or illegal load, held until cleared
// ----------------------------------------------------------------------------

module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             cin,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam bit PARAMS_OK = `COUNTER_PARAMS_LEGAL(WIDTH, MODULUS, RESET_VAL);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    // Stop elaboration on a parameter set that cannot work. Examples are a
    // modulus larger than the count width can hold, or a reset value outside
    // the count range.
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("mod_updown_counter: illegal WIDTH/MODULUS/RESET_VAL");
        end
    endgenerate

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             illegal_load;
    logic             ovf_set;

    // All modulo arithmetic lives in the step unit. This module adds only the
    // registers and the rst > load > en priority on top of it.
    mod_step_unit #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .count      (count),
        .step       (step),
        .cin        (cin),
        .up         (up),
        .next_count (step_next),
        .wrap_next  (step_wrap)
    );

    // Decide whether this cycle sets the sticky flag.
    // A load never counts, so while load is high only an out-of-range
    // load_val can set the flag. Otherwise the flag is set by an enabled
    // step that wraps.
    always_comb begin
        illegal_load = ({1'b0, load_val} >= MOD_W);
        ovf_set      = 1'b0;
        if (load) begin
            ovf_set = illegal_load;
        end else if (en) begin
            ovf_set = step_wrap;
        end
    end

    // State registers.
    // Reset overrides load, en and clear_ovf.
    // Load clamps an out-of-range value to MODULUS-1. That keeps the count
    // inside its range, so the step unit never sees an illegal count.
    // wrap is a one-cycle pulse and drops on any cycle that does not step.
    // For the sticky flag a set event beats clear_ovf in the same cycle, so
    // an overflow is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= RESET_W;
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (load) begin
                count <= illegal_load ? MAX_W : load_val;
                wrap  <= 1'b0;
            end else if (en) begin
                count <= step_next;
                wrap  <= step_wrap;
            end else begin
                wrap  <= 1'b0;
            end

            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (clear_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule : mod_updown_counter
